lb_interconnect_rr: RTL and testbench
=====================================

# lb_interconnect_rr

Parametrised N-channel local-bus arbiter: merges `C_CH_NUM` independent local-bus masters onto one downstream local-bus slave port. Each channel has a one-deep request latch, and channels are served round-robin. At most one read is outstanding at a time, and its return data is routed back to the originating channel. A sticky per-channel overflow flag reports lost requests. An optional read timeout releases a hung read.

## Interface
Parameters:
- `C_ADDR_WIDTH`, 16, address width.
- `C_DATA_WIDTH`, 32, data width.
- `C_CH_NUM`, 4, number of upstream channels (≥2).
- `C_TIMEOUT`, 1024, read timeout in cycles (≥2; used only with the timeout macro).
- `C_TIMEOUT_DATA`, 32'hDEADBEEF, data returned on timeout (truncated/zero-extended to `C_DATA_WIDTH`).

Ports:
- `LB_CLK_I` in 1: the single clock.
- `LB_RST_I` in 1: reset, synchronous, active-high.
- `LB_WADDR_I` in `C_CH_NUM*C_ADDR_WIDTH`: per-channel write address; channel i occupies slice i.
- `LB_WDATA_I` in `C_CH_NUM*C_DATA_WIDTH`: per-channel write data.
- `LB_WREQ_I` in `C_CH_NUM`: per-channel write request, single-cycle pulse.
- `LB_RADDR_I` in `C_CH_NUM*C_ADDR_WIDTH`: per-channel read address.
- `LB_RREQ_I` in `C_CH_NUM`: per-channel read request, single-cycle pulse.
- `LB_RDATA_O` out `C_CH_NUM*C_DATA_WIDTH`: per-channel read data, held until that channel's next return.
- `LB_RFINISH_O` out `C_CH_NUM`: per-channel read-done pulse.
- `LB_OVF_O` out `C_CH_NUM`: sticky per-channel request-dropped flag.
- `LB_WADDR_O`, `LB_WDATA_O`, `LB_WREQ_O` out: downstream write address, data and request.
- `LB_RADDR_O`, `LB_RREQ_O` out: downstream read address and request.
- `LB_RDATA_I` in `C_DATA_WIDTH`, `LB_RFINISH_I` in 1: downstream read return.
- `LB_TIMEOUT_O` out 1: pulses when a read is terminated by timeout.

## Operation
- Reset: all outputs, latches, flags and the counter go to 0; state is IDLE; the round-robin pointer is set so that channel 0 has highest priority.
- Latching:
  - A `LB_WREQ_I[i]` or `LB_RREQ_I[i]` pulse captures its address/data into that channel's write or read slot and sets the slot's pending bit.
  - Each channel has one write slot and one read slot.
- Overflow:
  - A request arriving while its slot is pending is dropped and sets `LB_OVF_O[i]`; the flag clears only on reset.
  - If a slot is granted and a new request for it arrives in the same cycle, the new request is captured and no overflow is raised.
- Arbitration (IDLE only):
  - The next channel with any pending slot, searching upward from last-granted+1 with wrap, is granted.
  - Within the granted channel the write is served before the read.
  - The pointer updates to the granted channel.
- States:
  - IDLE → IDLE on a write grant.
  - IDLE → RD_WAIT on a read grant.
  - RD_WAIT → IDLE on `LB_RFINISH_I` or timeout.
- Write: `LB_WREQ_O` pulses for 1 cycle with `LB_WADDR_O`/`LB_WDATA_O` valid in the same cycle.
- Read:
  - `LB_RREQ_O` pulses for 1 cycle with `LB_RADDR_O`.
  - `LB_RFINISH_I` is accepted from that cycle onward.
  - On finish, `LB_RDATA_I` is registered into the owning channel's `LB_RDATA_O` slice and `LB_RFINISH_O[owner]` pulses.
- `LB_RFINISH_I` outside RD_WAIT is ignored.
- Address/data outputs hold their last values between requests.

## Timing
- Request pulse in cycle k → downstream request in cycle k+1 when that channel wins.
- Writes can issue every cycle, e.g. one per channel on consecutive cycles.
- `LB_RFINISH_I` in cycle f → `LB_RFINISH_O`/`LB_RDATA_O` valid in cycle f+1 → next grant issues no earlier than cycle f+1.
- Reset mid-read: the outstanding read is abandoned and no `LB_RFINISH_O` is produced.

## Configuration
- `LB_IC_RD_TIMEOUT_EN` defined:
  - The counter starts with `LB_RREQ_O`.
  - After `C_TIMEOUT` cycles in RD_WAIT without finish, the owner receives `C_TIMEOUT_DATA` with an `LB_RFINISH_O` pulse and `LB_TIMEOUT_O` pulses in the same cycle; state returns to IDLE.
  - Finish and expiry in the same cycle: finish wins.
- Undefined: no counter; RD_WAIT waits indefinitely; `LB_TIMEOUT_O` is tied to 0.

## Test plan
- Simultaneous writes: ch0 (addr 10, 0x11223344) and ch1 (addr 20, 0xFFEEFFEE) pulsed in cycle k → `LB_WREQ_O` in k+1 with ch0 values and in k+2 with ch1 values; `LB_OVF_O`=0.
- Simultaneous reads:
  - Stimulus: ch0 read 0x8888 and ch1 read 0x9999; `LB_RFINISH_I` with 0xEEEEEEEE, then later with 0x33333333.
  - Response: ch0 slice = 0xEEEEEEEE and ch1 slice = 0x33333333, each with its own `LB_RFINISH_O` pulse; ch1's `LB_RREQ_O` occurs only after ch0's finish.
- Round-robin: all 4 channels hold writes continuously → grant order 0,1,2,3,0…, never the same channel twice in a row while others are pending.
- Overflow: ch2 read pending while a read is outstanding, then a second ch2 read pulse → `LB_OVF_O[2]`=1 and stays 1; only the first ch2 read issues.
- Timeout (macro on, `C_TIMEOUT`=16): read with no finish → at 16 cycles the owner gets 0xDEADBEEF, `LB_RFINISH_O` and `LB_TIMEOUT_O` pulse; a late `LB_RFINISH_I` is ignored.
- Reset during RD_WAIT: assert `LB_RST_I` 1 cycle → all outputs 0; a following `LB_RFINISH_I` yields no `LB_RFINISH_O`.

Source files
------------

// File: rtl/lb_interconnect_rr.sv
// Round-robin N-channel local-bus arbiter with per-channel one-deep request latches.
// Optional read timeout is enabled by defining LB_IC_RD_TIMEOUT_EN.
module lb_interconnect_rr #(
    parameter int unsigned C_ADDR_WIDTH   = 16,
    parameter int unsigned C_DATA_WIDTH   = 32,
    parameter int unsigned C_CH_NUM       = 4,
    parameter int unsigned C_TIMEOUT      = 1024,
    parameter logic [31:0] C_TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic                             LB_CLK_I,
    input  logic                             LB_RST_I,
    input  logic [C_CH_NUM*C_ADDR_WIDTH-1:0] LB_WADDR_I,
    input  logic [C_CH_NUM*C_DATA_WIDTH-1:0] LB_WDATA_I,
    input  logic [C_CH_NUM-1:0]              LB_WREQ_I,
    input  logic [C_CH_NUM*C_ADDR_WIDTH-1:0] LB_RADDR_I,
    input  logic [C_CH_NUM-1:0]              LB_RREQ_I,
    output logic [C_CH_NUM*C_DATA_WIDTH-1:0] LB_RDATA_O,
    output logic [C_CH_NUM-1:0]              LB_RFINISH_O,
    output logic [C_CH_NUM-1:0]              LB_OVF_O,
    output logic [C_ADDR_WIDTH-1:0]          LB_WADDR_O,
    output logic [C_DATA_WIDTH-1:0]          LB_WDATA_O,
    output logic                             LB_WREQ_O,
    output logic [C_ADDR_WIDTH-1:0]          LB_RADDR_O,
    output logic                             LB_RREQ_O,
    input  logic [C_DATA_WIDTH-1:0]          LB_RDATA_I,
    input  logic                             LB_RFINISH_I,
    output logic                             LB_TIMEOUT_O
);
    localparam int unsigned PW = $clog2(C_CH_NUM);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t                                state_q, state_d;
    logic [PW-1:0]                         ptr_q, ptr_d, owner_q, owner_d;
    logic [C_CH_NUM-1:0]                   wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic [C_CH_NUM-1:0]                   ovf_q, ovf_d;
    logic [C_CH_NUM-1:0][C_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [C_CH_NUM-1:0][C_DATA_WIDTH-1:0] wr_data_q, wr_data_d, rdata_q, rdata_d;
    logic [C_CH_NUM-1:0]                   rfinish_q, rfinish_d;
    logic [C_ADDR_WIDTH-1:0]               waddr_q, waddr_d, raddr_q, raddr_d;
    logic [C_DATA_WIDTH-1:0]               wdata_q, wdata_d;
    logic                                  wreq_q, wreq_d, rreq_q, rreq_d;

    logic [C_CH_NUM-1:0] wr_eff, rd_eff;
    logic                gnt_found, do_wr, do_rd;
    logic [PW-1:0]       gnt_ch, cand;
    int unsigned         idx;

`ifdef LB_IC_RD_TIMEOUT_EN
    localparam int unsigned CW = $clog2(C_TIMEOUT);
    localparam logic [C_DATA_WIDTH-1:0] TO_DATA = C_DATA_WIDTH'(C_TIMEOUT_DATA);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        wr_pend_d = wr_pend_q;
        rd_pend_d = rd_pend_q;
        ovf_d     = ovf_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        rfinish_d = '0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        raddr_d   = raddr_q;
        wreq_d    = 1'b0;
        rreq_d    = 1'b0;
`ifdef LB_IC_RD_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif

        // Incoming pulses take part in arbitration directly so a winning request
        // reaches the downstream port one cycle after it arrives.
        wr_eff    = wr_pend_q | LB_WREQ_I;
        rd_eff    = rd_pend_q | LB_RREQ_I;
        gnt_found = 1'b0;
        gnt_ch    = ptr_q;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 1; k <= C_CH_NUM; k++) begin
            idx  = (32'(ptr_q) + k) % C_CH_NUM;
            cand = PW'(idx);
            if (!gnt_found && (wr_eff[cand] || rd_eff[cand])) begin
                gnt_found = 1'b1;
                gnt_ch    = cand;
            end
        end

        do_wr = (state_q == IDLE) && gnt_found && wr_eff[gnt_ch];
        do_rd = (state_q == IDLE) && gnt_found && !wr_eff[gnt_ch];

        if (do_wr) begin
            waddr_d = wr_pend_q[gnt_ch] ? wr_addr_q[gnt_ch]
                                        : LB_WADDR_I[32'(gnt_ch)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            wdata_d = wr_pend_q[gnt_ch] ? wr_data_q[gnt_ch]
                                        : LB_WDATA_I[32'(gnt_ch)*C_DATA_WIDTH +: C_DATA_WIDTH];
            wreq_d  = 1'b1;
            ptr_d   = gnt_ch;
        end
        if (do_rd) begin
            raddr_d = rd_pend_q[gnt_ch] ? rd_addr_q[gnt_ch]
                                        : LB_RADDR_I[32'(gnt_ch)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            rreq_d  = 1'b1;
            ptr_d   = gnt_ch;
            owner_d = gnt_ch;
            state_d = RD_WAIT;
`ifdef LB_IC_RD_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end

        // A slot granted this cycle may take a new pulse without overflowing.
        for (int unsigned c = 0; c < C_CH_NUM; c++) begin
            if (do_wr && gnt_ch == PW'(c)) begin
                wr_pend_d[c] = wr_pend_q[c] & LB_WREQ_I[c];
                if (wr_pend_q[c] && LB_WREQ_I[c]) begin
                    wr_addr_d[c] = LB_WADDR_I[c*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                    wr_data_d[c] = LB_WDATA_I[c*C_DATA_WIDTH +: C_DATA_WIDTH];
                end
            end else if (LB_WREQ_I[c]) begin
                if (wr_pend_q[c]) begin
                    ovf_d[c] = 1'b1;
                end else begin
                    wr_pend_d[c] = 1'b1;
                    wr_addr_d[c] = LB_WADDR_I[c*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                    wr_data_d[c] = LB_WDATA_I[c*C_DATA_WIDTH +: C_DATA_WIDTH];
                end
            end

            if (do_rd && gnt_ch == PW'(c)) begin
                rd_pend_d[c] = rd_pend_q[c] & LB_RREQ_I[c];
                if (rd_pend_q[c] && LB_RREQ_I[c]) begin
                    rd_addr_d[c] = LB_RADDR_I[c*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                end
            end else if (LB_RREQ_I[c]) begin
                if (rd_pend_q[c]) begin
                    ovf_d[c] = 1'b1;
                end else begin
                    rd_pend_d[c] = 1'b1;
                    rd_addr_d[c] = LB_RADDR_I[c*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                end
            end
        end

        if (state_q == RD_WAIT) begin
            if (LB_RFINISH_I) begin
                rdata_d[owner_q]   = LB_RDATA_I;
                rfinish_d[owner_q] = 1'b1;
                state_d            = IDLE;
`ifdef LB_IC_RD_TIMEOUT_EN
            end else if (cnt_q == CW'(C_TIMEOUT - 1)) begin
                rdata_d[owner_q]   = TO_DATA;
                rfinish_d[owner_q] = 1'b1;
                timeout_d          = 1'b1;
                state_d            = IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge LB_CLK_I) begin
        if (LB_RST_I) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(C_CH_NUM - 1);
            owner_q   <= '0;
            wr_pend_q <= '0;
            rd_pend_q <= '0;
            ovf_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            rfinish_q <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
            wreq_q    <= 1'b0;
            rreq_q    <= 1'b0;
`ifdef LB_IC_RD_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            ovf_q     <= ovf_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            rfinish_q <= rfinish_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            raddr_q   <= raddr_d;
            wreq_q    <= wreq_d;
            rreq_q    <= rreq_d;
`ifdef LB_IC_RD_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign LB_RDATA_O   = rdata_q;
    assign LB_RFINISH_O = rfinish_q;
    assign LB_OVF_O     = ovf_q;
    assign LB_WADDR_O   = waddr_q;
    assign LB_WDATA_O   = wdata_q;
    assign LB_WREQ_O    = wreq_q;
    assign LB_RADDR_O   = raddr_q;
    assign LB_RREQ_O    = rreq_q;
`ifdef LB_IC_RD_TIMEOUT_EN
    assign LB_TIMEOUT_O = timeout_q;
`else
    assign LB_TIMEOUT_O = 1'b0;
`endif

endmodule

// File: tb/tb_lb_interconnect_rr.sv
// Scoreboard bench for lb_interconnect_rr: downstream transactions and upstream
// read returns are queued when stimulus is driven and checked as they appear.
module tb_lb_interconnect_rr;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int CH = 4;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*AW-1:0] waddr_i, raddr_i;
    logic [CH*DW-1:0] wdata_i;
    logic [CH-1:0]    wreq_i, rreq_i;
    logic [CH*DW-1:0] rdata_o;
    logic [CH-1:0]    rfinish_o, ovf_o;
    logic [AW-1:0]    waddr_o, raddr_o;
    logic [DW-1:0]    wdata_o;
    logic             wreq_o, rreq_o;
    logic [DW-1:0]    rdata_i;
    logic             rfinish_i;
    logic             timeout_o;

    always #5 clk = ~clk;

    lb_interconnect_rr #(
        .C_ADDR_WIDTH(AW),
        .C_DATA_WIDTH(DW),
        .C_CH_NUM(CH),
        .C_TIMEOUT(TO),
        .C_TIMEOUT_DATA(32'hDEADBEEF)
    ) dut (
        .LB_CLK_I(clk),
        .LB_RST_I(rst),
        .LB_WADDR_I(waddr_i),
        .LB_WDATA_I(wdata_i),
        .LB_WREQ_I(wreq_i),
        .LB_RADDR_I(raddr_i),
        .LB_RREQ_I(rreq_i),
        .LB_RDATA_O(rdata_o),
        .LB_RFINISH_O(rfinish_o),
        .LB_OVF_O(ovf_o),
        .LB_WADDR_O(waddr_o),
        .LB_WDATA_O(wdata_o),
        .LB_WREQ_O(wreq_o),
        .LB_RADDR_O(raddr_o),
        .LB_RREQ_O(rreq_o),
        .LB_RDATA_I(rdata_i),
        .LB_RFINISH_I(rfinish_i),
        .LB_TIMEOUT_O(timeout_o)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned failed = 0;

    // downstream entry: {is_write, addr, data}; upstream entry: {owner, timeout, data}
    logic [48:0] dq[$];
    logic [34:0] rq[$];
    int unsigned cyc = 0;
    int unsigned issue_cyc = 0;
    logic        outstanding = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        waddr_i[ch*AW +: AW] = a;
        wdata_i[ch*DW +: DW] = d;
        wreq_i[ch] = 1'b1;
        dq.push_back({1'b1, a, d});
    endtask

    task automatic set_rd(input int ch, input logic [AW-1:0] a);
        raddr_i[ch*AW +: AW] = a;
        rreq_i[ch] = 1'b1;
    endtask

    task automatic pulse();
        tick();
        wreq_i = '0;
        rreq_i = '0;
    endtask

    task automatic finish(input logic [DW-1:0] d);
        rdata_i   = d;
        rfinish_i = 1'b1;
        tick();
        rfinish_i = 1'b0;
    endtask

    task automatic wait_rreq(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rreq_o) break;
            tick();
        end
        check("rreq_seen", rreq_o, 1'b1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (dq.size() == 0 && rq.size() == 0) break;
            tick();
        end
        check("drain", dq.size() + rq.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [48:0] got;
        logic [48:0] e;
        logic [34:0] r;
        cyc++;
        if (rst) begin
            outstanding = 1'b0;
        end else begin
            if (wreq_o || rreq_o) begin
                got = {wreq_o, wreq_o ? waddr_o : raddr_o, wreq_o ? wdata_o : 32'h0};
                if (dq.size() == 0) begin
                    check("dn_unexpected", {wreq_o, rreq_o}, 0);
                end else begin
                    e = dq.pop_front();
                    check("dn_txn", got, e);
                end
                if (rreq_o) begin
                    check("rd_one_outstanding", outstanding, 0);
                    outstanding = 1'b1;
                    issue_cyc   = cyc;
                end
            end
            if (|rfinish_o) begin
                if (rq.size() == 0) begin
                    check("up_unexpected", rfinish_o, 0);
                end else begin
                    r = rq.pop_front();
                    check("up_owner", rfinish_o, 4'b0001 << r[34:33]);
                    check("up_data", rdata_o[r[34:33]*DW +: DW], r[31:0]);
                    check("up_timeout_flag", timeout_o, r[32]);
                    if (r[32]) check("to_latency", cyc - issue_cyc, TO);
                end
                outstanding = 1'b0;
            end else if (timeout_o) begin
                check("timeout_alone", timeout_o, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        waddr_i = '0; wdata_i = '0; wreq_i = '0;
        raddr_i = '0; rreq_i = '0;
        rdata_i = '0; rfinish_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_ctrl", {wreq_o, rreq_o, rfinish_o, ovf_o, timeout_o, waddr_o, raddr_o}, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_rdata", rdata_o, 0);

        // Round robin: all four channels, re-pulsed as channel 3 is granted.
        for (int c = 0; c < CH; c++) set_wr(c, AW'(16'h100 + c), 32'hA0 + c);
        pulse();
        tick();
        tick();
        for (int c = 0; c < CH; c++) set_wr(c, AW'(16'h200 + c), 32'hB0 + c);
        pulse();
        wait_drain(20);
        check("rr_no_ovf", ovf_o, 0);

        // Simultaneous writes ch0/ch1 with channel 0 next in line.
        set_wr(0, 16'd10, 32'h11223344);
        set_wr(1, 16'd20, 32'hFFEEFFEE);
        pulse();
        check("wr_k1", {wreq_o, waddr_o, wdata_o}, {1'b1, 16'd10, 32'h11223344});
        tick();
        check("wr_k2", {wreq_o, waddr_o, wdata_o}, {1'b1, 16'd20, 32'hFFEEFFEE});
        wait_drain(10);
        check("wr_no_ovf", ovf_o, 0);

        // Pointer at ch1: ch2 must beat ch0.
        set_wr(0, 16'h0AAA, 32'h0000AAAA);
        dq.delete();
        set_wr(2, 16'h0CCC, 32'h0000CCCC);
        set_wr(0, 16'h0AAA, 32'h0000AAAA);
        wreq_i[0] = 1'b1;
        pulse();
        wait_drain(10);

        // Move the pointer to ch3 so ch0 leads the read test.
        set_wr(3, 16'h0333, 32'h33330000);
        pulse();
        wait_drain(10);

        // Simultaneous reads, second issues only after first completes.
        dq.push_back({1'b0, 16'h8888, 32'h0});
        dq.push_back({1'b0, 16'h9999, 32'h0});
        rq.push_back({2'd0, 1'b0, 32'hEEEEEEEE});
        rq.push_back({2'd1, 1'b0, 32'h33333333});
        set_rd(0, 16'h8888);
        set_rd(1, 16'h9999);
        pulse();
        wait_rreq(10);
        repeat (3) tick();
        finish(32'hEEEEEEEE);
        wait_rreq(10);
        repeat (2) tick();
        finish(32'h33333333);
        wait_drain(10);
        check("ch0_rdata_held", rdata_o[0 +: DW], 32'hEEEEEEEE);
        finish(32'h01010101);
        check("idle_finish_ignored", rfinish_o, 0);

        // Overflow on ch2 while ch0's read is outstanding.
        dq.push_back({1'b0, 16'h1000, 32'h0});
        dq.push_back({1'b0, 16'h2222, 32'h0});
        rq.push_back({2'd0, 1'b0, 32'h0000000A});
        rq.push_back({2'd2, 1'b0, 32'h0000000B});
        set_rd(0, 16'h1000);
        pulse();
        wait_rreq(10);
        tick();
        set_rd(2, 16'h2222);
        pulse();
        check("ovf_first_ok", ovf_o, 0);
        set_rd(2, 16'h3333);
        pulse();
        check("ovf_set", ovf_o, 4'b0100);
        finish(32'h0000000A);
        wait_rreq(10);
        tick();
        finish(32'h0000000B);
        wait_drain(10);
        check("ovf_sticky", ovf_o, 4'b0100);

`ifdef LB_IC_RD_TIMEOUT_EN
        dq.push_back({1'b0, 16'h4444, 32'h0});
        rq.push_back({2'd3, 1'b1, 32'hDEADBEEF});
        set_rd(3, 16'h4444);
        pulse();
        wait_drain(TO + 10);
        finish(32'h12345678);
        check("late_finish_ignored", rfinish_o, 0);
`else
        dq.push_back({1'b0, 16'h4444, 32'h0});
        set_rd(3, 16'h4444);
        pulse();
        wait_rreq(10);
        repeat (40) tick();
        check("no_timeout", {timeout_o, rfinish_o}, 0);
        rq.push_back({2'd3, 1'b0, 32'h55555555});
        finish(32'h55555555);
        wait_drain(10);
`endif

        // Reset while a read is outstanding.
        dq.push_back({1'b0, 16'h7777, 32'h0});
        set_rd(1, 16'h7777);
        pulse();
        wait_rreq(10);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ctrl", {wreq_o, rreq_o, rfinish_o, ovf_o, timeout_o, waddr_o, raddr_o}, 0);
        check("mid_rst_wdata", wdata_o, 0);
        check("mid_rst_rdata", rdata_o, 0);
        finish(32'h66666666);
        check("post_rst_no_finish", rfinish_o, 0);
        repeat (3) tick();
        set_wr(2, 16'h0123, 32'hCAFEF00D);
        pulse();
        wait_drain(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
